// File: rtl/ov7670_pkg.sv
// Shared constants and state encoding for the OV7670 capture path.
package ov7670_pkg;

    localparam int unsigned H_RES_DEF    = 640;
    localparam int unsigned V_RES_DEF    = 480;
    localparam int unsigned FRAME_PIXELS = H_RES_DEF * V_RES_DEF;
    localparam int unsigned ADDR_W       = 19;
    localparam int unsigned PIX_W        = 12;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        CAPTURE,
        SKIP
    } cap_state_t;

endpackage

// File: rtl/ov7670_byte_packer.sv
// Pairs registered camera bytes into RGB444 pixels and flags lines ending mid-pixel.
module ov7670_byte_packer
    import ov7670_pkg::*;
(
    input  logic             pclk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             href_q,
    input  logic [7:0]       d_q,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic             odd_err
);

    logic       phase;
    logic [3:0] hi;
    logic       href_prev;

    assign pix_valid = en & href_q & phase;
    assign pix_data  = {hi, d_q};
    assign odd_err   = en & href_prev & ~href_q & phase;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            phase     <= 1'b0;
            hi        <= '0;
            href_prev <= 1'b0;
        end else begin
            href_prev <= href_q;
            if (!en) begin
                phase <= 1'b0;
            end else if (href_q) begin
                if (!phase)
                    hi <= d_q[3:0];
                phase <= ~phase;
            end else begin
                // href gap drops any half-assembled pixel
                phase <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ov7670_capture.sv
// Camera-domain frame writer: syncs to vsync, packs bytes, emits linear write strobes.
module ov7670_capture
    import ov7670_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF
) (
    input  logic              pclk,
    input  logic              reset_n,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_d,
    input  logic              capture_en,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [PIX_W-1:0]  frame_pixel,
    output logic              frame_we,
    output logic              frame_done,
    output logic              frame_err
);

    localparam logic [ADDR_W-1:0] FRAME_PIX = ADDR_W'(H_RES * V_RES);

    logic              vs_q, vs_prev, href_q;
    logic [7:0]        d_q;
    cap_state_t        state;
    logic [ADDR_W-1:0] wr_addr;
    logic              err_flag;
    logic              vs_rise, vs_fall;
    logic              pack_en, pix_valid, odd_err;
    logic [PIX_W-1:0]  pix_data;

    assign vs_rise = vs_q & ~vs_prev;
    assign vs_fall = ~vs_q & vs_prev;
    // vsync rising wins over a pixel completing in the same cycle
    assign pack_en = (state == CAPTURE) && !vs_rise;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q    <= 1'b0;
            vs_prev <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= '0;
        end else begin
            vs_q    <= cam_vsync;
            vs_prev <= vs_q;
            href_q  <= cam_href;
            d_q     <= cam_d;
        end
    end

    ov7670_byte_packer u_packer (
        .pclk      (pclk),
        .reset_n   (reset_n),
        .en        (pack_en),
        .href_q    (href_q),
        .d_q       (d_q),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .odd_err   (odd_err)
    );

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wr_addr     <= '0;
            err_flag    <= 1'b0;
            frame_addr  <= '0;
            frame_pixel <= '0;
            frame_we    <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_we   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (vs_q)
                        state <= SYNC;
                end
                SYNC: begin
                    wr_addr  <= '0;
                    err_flag <= 1'b0;
                    if (vs_fall)
                        state <= capture_en ? CAPTURE : SKIP;
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        frame_done <= 1'b1;
                        frame_err  <= err_flag | (wr_addr != FRAME_PIX);
                        state      <= SYNC;
                    end else begin
                        if (pix_valid) begin
                            if (wr_addr < FRAME_PIX) begin
                                frame_we    <= 1'b1;
                                frame_addr  <= wr_addr;
                                frame_pixel <= pix_data;
                                wr_addr     <= wr_addr + ADDR_W'(1);
                            end else begin
                                err_flag <= 1'b1;
                            end
                        end
                        if (odd_err)
                            err_flag <= 1'b1;
                    end
                end
                SKIP: begin
                    if (vs_rise)
                        state <= SYNC;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
